sqrt_seq_ctrl: RTL and testbench
================================

Name: sqrt_seq_ctrl

Overview:
Sequential controller for the 6-digit BCD integer square-root function. It accepts a BCD radicand with a start/busy/done handshake and runs three phases on shared registers:
- BCD-to-binary accumulation.
- 16-step non-restoring square root, one step per clock.
- Binary-to-BCD double-dabble conversion.

It replaces the single-cycle combinational path with a small, fixed-latency, clocked unit that sits between the keypad/display front end and the display driver.

Parameters:
None. Widths are fixed:
- Input and output: 6 BCD digits (24 bits).
- Radicand: 32 bits.
- Root: 16 bits.
- Remainder: 18 bits.

Ports:
clk      in   1   system clock, rising edge
rst_n    in   1   asynchronous active-low reset
start    in   1   request; sampled only in IDLE
in_dec   in   24  BCD radicand, [23:20] = most significant digit; captured on the accepting edge
busy     out  1   high while a request is in progress
done     out  1   one-cycle pulse; out_dec and err are valid on this cycle
err      out  1   set when any input nibble is greater than 9; held until the next accept
out_dec  out  24  BCD floor(sqrt(radicand)); held from done until the next accept

Behaviour:
Reset (asynchronous, rst_n=0):
- State goes to IDLE.
- busy=0, done=0, err=0, out_dec=0.
- All internal registers are cleared.
- Reset mid-operation aborts the request; no done pulse is produced.

States: IDLE, LOAD, ROOT, CONV, DONE. A 5-bit step counter is shared by LOAD, ROOT and CONV.

IDLE:
- start=1 on a clock edge accepts the request:
  - in_dec is latched into a digit shift register.
  - err is cleared; out_dec is held.
  - busy goes to 1.
- If any latched nibble is greater than 9:
  - Next state is DONE with err=1 and out_dec=0.
  - done is high exactly one cycle after the accepting edge.
- Otherwise the next state is LOAD.

LOAD (6 cycles):
- Each cycle: acc = acc*10 + top digit, then the digits shift left by one nibble. The most significant digit is consumed first.
- acc is 32 bits; the maximum value is 999999.

ROOT (16 cycles), with a = acc, q = 0, r = 0 at entry. Each cycle, in order:
- right = {q, r[17], 1'b1}
- left = {r[15:0], a[31:30]}
- a shifts left by 2.
- r = (r[17] ? left + right : left - right), truncated to 18 bits.
- q = {q[14:0], ~r[17]}

After 16 cycles, q equals floor(sqrt(acc)).

CONV (16 cycles):
- Double-dabble on q into a 24-bit BCD register that starts at 0.
- Each cycle: every BCD nibble that is 5 or more gets +3, then the {bcd, q} register shifts left by 1.

DONE (1 cycle):
- done=1.
- out_dec is loaded from the BCD register (or 0 on error) on the edge entering DONE.
- busy is still 1 during DONE.
- The next state is always IDLE.

Latency and handshake:
- Valid path: done is asserted 39 cycles after the accepting edge (6 + 16 + 16 + 1), and busy is high for 39 cycles.
- Back-to-back requests: start is ignored in every state except IDLE, including DONE. The minimum request spacing is 40 cycles.
- in_dec changes after the accepting edge have no effect.
- The result is always at most 999, so out_dec[23:12] is 0 on every valid completion.

Test Plan:
1. Reset, then start with in_dec=24'h000144: busy rises on the next cycle, done pulses 39 cycles after accept, out_dec=24'h000012, err=0.
2. in_dec=24'h999999: out_dec=24'h000999 after 39 cycles. in_dec=24'h000000: out_dec=0. in_dec=24'h000002: out_dec=24'h000001 (floor).
3. Invalid digit, in_dec=24'h00012A: done one cycle after accept, err=1, out_dec=0, busy back to 0 on the following cycle. A subsequent valid request clears err.
4. Start held high and in_dec changed to 24'h000081 during the first request: no second accept until IDLE. The first result (for 24'h000144) is 12. A second accept occurs on the first IDLE cycle and returns 9.
5. Assert rst_n=0 during ROOT (cycle 15 after accept): all outputs are 0 immediately and no done pulse follows. A new start of 24'h010000 then returns 24'h000100.
6. Randomised: 200 valid BCD inputs, each compared with an integer floor-sqrt model. Check the exact 39-cycle latency and that out_dec is stable between done pulses.

Source files
------------

// File: rtl/sqrt_seq_ctrl.sv
// Sequential 6-digit BCD integer square root: BCD->binary, 16-step non-restoring root,
// double-dabble back to BCD, behind a start/busy/done handshake.
module sqrt_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] in_dec,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] out_dec
);

    localparam int unsigned DEC_W = 24;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned Q_W   = 16;
    localparam int unsigned REM_W = 18;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROOT,
        S_CONV,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [DEC_W-1:0]   r_digits, w_digits_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [Q_W-1:0]     r_q, w_q_nxt;
    logic [REM_W-1:0]   r_rem, w_rem_nxt;
    logic [DEC_W-1:0]   r_bcd, w_bcd_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic [DEC_W-1:0]   r_out, w_out_nxt;

    logic               w_bad;
    logic [REM_W-1:0]   w_right, w_left, w_rem_step;
    logic [DEC_W-1:0]   w_bcd_adj;

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign out_dec = r_out;

    // Any non-decimal nibble on the incoming radicand
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (in_dec[i*4 +: 4] > 4'd9) w_bad = 1'b1;
        end
    end

    // One non-restoring root step; r[17] is the sign of the partial remainder
    always_comb begin
        w_right    = {r_q, r_rem[17], 1'b1};
        w_left     = {r_rem[15:0], r_acc[31:30]};
        w_rem_step = r_rem[17] ? (w_left + w_right) : (w_left - w_right);
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 6; i++) begin
            w_bcd_adj[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5) ? (r_bcd[i*4 +: 4] + 4'd3)
                                                             : r_bcd[i*4 +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_digits_nxt = r_digits;
        w_acc_nxt    = r_acc;
        w_q_nxt      = r_q;
        w_rem_nxt    = r_rem;
        w_bcd_nxt    = r_bcd;
        w_err_nxt    = r_err;
        w_out_nxt    = r_out;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_digits_nxt = in_dec;
                    w_cnt_nxt    = '0;
                    w_acc_nxt    = '0;
                    w_q_nxt      = '0;
                    w_rem_nxt    = '0;
                    w_bcd_nxt    = '0;
                    w_err_nxt    = w_bad;
                    if (w_bad) begin
                        w_out_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_acc_nxt    = {r_acc[28:0], 3'b000} + {r_acc[30:0], 1'b0}
                             + ACC_W'(r_digits[23:20]);
                w_digits_nxt = {r_digits[19:0], 4'h0};
                w_cnt_nxt    = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(5)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ROOT;
                end
            end
            S_ROOT: begin
                w_acc_nxt = {r_acc[29:0], 2'b00};
                w_rem_nxt = w_rem_step;
                w_q_nxt   = {r_q[14:0], ~w_rem_step[17]};
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(15)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                w_bcd_nxt = {w_bcd_adj[22:0], r_q[15]};
                w_q_nxt   = {r_q[14:0], 1'b0};
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(15)) begin
                    w_cnt_nxt   = '0;
                    w_out_nxt   = {w_bcd_adj[22:0], r_q[15]};
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_digits <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_bcd    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_out    <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_digits <= w_digits_nxt;
            r_acc    <= w_acc_nxt;
            r_q      <= w_q_nxt;
            r_rem    <= w_rem_nxt;
            r_bcd    <= w_bcd_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_out    <= w_out_nxt;
        end
    end

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Scoreboard bench for sqrt_seq_ctrl: requests push expected results, a negedge
// monitor pops and checks value, error flag, completion cycle and output hold.
module tb_sqrt_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] in_dec = 24'h0;
    logic        busy, done, err;
    logic [23:0] out_dec;

    sqrt_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_dec  (in_dec),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .out_dec (out_dec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [23:0] out;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] last_out = 24'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest expectation; output holds otherwise
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_out = 24'h0;
        end else if (done) begin
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_dec", 32'(out_dec), 32'(e.out));
                chk("err", 32'(err), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
            last_out = out_dec;
        end else begin
            chk("out_stable", 32'(out_dec), 32'(last_out));
        end
    end

    function automatic int isqrt(input int v);
        int s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] b = 24'h0;
        for (int i = 0; i < 6; i++) begin
            b[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy && !done) return;
            @(negedge clk);
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic req(input logic [23:0] v, input logic [23:0] eo, input logic ee);
        exp_t e;
        wait_idle();
        in_dec = v;
        start  = 1'b1;
        e.out  = eo;
        e.err  = ee;
        e.cyc  = cyc + 1 + (ee ? 0 : 38);
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        in_dec = ~v;
        chk("busy_rise", 32'(busy), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        logic [23:0] v;
        int val;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out", 32'(out_dec), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and boundary values
        req(24'h000144, 24'h000012, 1'b0);
        req(24'h999999, 24'h000999, 1'b0);
        req(24'h000000, 24'h000000, 1'b0);
        req(24'h000002, 24'h000001, 1'b0);

        // Invalid digit: immediate completion, then error cleared by a valid request
        req(24'h00012A, 24'h000000, 1'b1);
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'd0);
        req(24'h000002, 24'h000001, 1'b0);

        // Start held high: second accept only on the first IDLE cycle
        wait_idle();
        in_dec = 24'h000144;
        start  = 1'b1;
        c      = cyc;
        sb.push_back('{out: 24'h000012, err: 1'b0, cyc: c + 1 + 38});
        sb.push_back('{out: 24'h000009, err: 1'b0, cyc: c + 1 + 40 + 38});
        @(negedge clk);
        in_dec = 24'h000081;
        while (cyc < c + 41) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wait_idle();

        // Reset during ROOT aborts with no completion
        in_dec = 24'h000144;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_out", 32'(out_dec), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        req(24'h010000, 24'h000100, 1'b0);

        // Random valid radicands against an integer model
        for (int n = 0; n < 200; n++) begin
            val = 0;
            for (int d = 5; d >= 0; d--) begin
                v[d*4 +: 4] = 4'($urandom_range(0, 9));
                val = val * 10 + int'(v[d*4 +: 4]);
            end
            req(v, to_bcd(isqrt(val)), 1'b0);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
